fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Consumer end of the program counter interface: reads `current` from ProgramCounter, fetches the instruction word at that address from instruction memory over a req/ack handshake, and presents it to the decoder on a valid/ready interface.
- Drives the PC's `update_en` to advance the PC in INC mode after each successful fetch.
- Supports flush for redirects (PC SET/ADD driven by branch logic) and discards stale in-flight data.

Parameters:
XLEN, 32, address/instruction width (matches `XBUS`)
RESET_ADDR_CHECK, 0, reserved; must be 0

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
pc_current  in  XLEN  PC `current` output
pc_update_en  out  1  to PC `update_en`; PC mode is INC while this is high
mem_addr  out  XLEN  fetch address, equals pc_current while mem_req=1
mem_req  out  1  fetch request, registered
mem_ack  in  1  one-cycle completion strobe; mem_rdata valid same cycle
mem_rdata  in  XLEN  fetched word
instr  out  XLEN  instruction to decoder, registered
instr_pc  out  XLEN  address of instr, registered
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decoder accepts
flush  in  1  discard current/in-flight instruction; PC is being redirected this cycle

Behaviour:
- Reset (async, while rst=1): state=IDLE; mem_req=0; instr_valid=0; instr=0; instr_pc=0. pc_update_en is combinational and therefore also 0 in IDLE.
- States: IDLE, REQ, HOLD, DRAIN (encoding in package).
- IDLE: unconditionally -> REQ on the first posedge after rst deasserts; mem_req=1 from then.
- REQ:
  - mem_req=1; mem_addr=pc_current (combinational). The PC must not change while in REQ without mem_ack.
  - mem_ack=1 and flush=0: pc_update_en=1 (combinational, same cycle). At the edge: instr<=mem_rdata, instr_pc<=mem_addr, instr_valid<=1, mem_req<=0, -> HOLD.
  - mem_ack=1 and flush=1: pc_update_en=0, data dropped, -> REQ with mem_req kept at 1. The next cycle uses the redirected pc_current.
  - flush=1 without mem_ack: -> DRAIN. mem_req stays 1; the request is never withdrawn before ack.
- HOLD:
  - instr_valid=1; instr/instr_pc stable until accepted.
  - instr_ready=1 and flush=0: at the edge instr_valid<=0, mem_req<=1, -> REQ.
  - flush=1: instr_valid<=0, mem_req<=1, -> REQ, regardless of instr_ready.
- DRAIN:
  - mem_req=1; mem_addr holds the address registered at the flush edge, not pc_current.
  - On mem_ack: data dropped, pc_update_en=0, -> REQ (mem_req stays 1).
  - flush in DRAIN: no effect.
- mem_ack while mem_req=0 or in IDLE/HOLD: ignored.
- Throughput: one instruction per 2 cycles minimum (REQ with immediate ack, HOLD with immediate ready).
- Reset mid-fetch: outstanding request abandoned. Memory must tolerate mem_req dropping without ack.

Optional Feature:
FETCH_FAULT_EN
- Defined:
  - Adds input mem_err (1) and output instr_fault (1, reset 0).
  - mem_ack with mem_err=1 in REQ: instr_fault<=1, instr<=0, instr_valid<=1, pc_update_en=0 (PC not advanced), -> HOLD.
  - After the faulted instruction is accepted or flushed: instr_fault<=0.
  - After acceptance of a faulted instruction, the unit goes to IDLE and stays there until flush=1, then -> REQ.
- Undefined: no extra ports; errors are not modelled.

Decomposition:
- defs.v gains `FETCH_STATE_MSB`, `FETCH_IDLE`, `FETCH_REQ`, `FETCH_HOLD`, `FETCH_DRAIN`; reuses `XBUS`.
- No sub-module; the single-entry instruction register is inline. The bench instantiates ProgramCounter + fetch_unit + a behavioural memory with programmable ack latency.

Test Plan:
- Reset, PC=0, mem ack latency 0, instr_ready=1 -> instr_pc sequence 0,4,8 with instr=mem[0],mem[4],mem[8]; instr_valid high every other cycle.
- Ack latency 3 cycles -> mem_addr=0x4 held stable for 3 cycles; pc_update_en exactly one cycle per fetch; PC advances 4 per fetch.
- instr_ready low 5 cycles while instr=mem[0x8] valid -> instr, instr_pc=0x8 stable; no new mem_req; PC stays 0xC.
- Flush with PC SET to 0x124 during HOLD at instr_pc=0x20 -> instr_valid drops; next fetch mem_addr=0x124; 0x20 never accepted.
- Flush during REQ with ack latency 2 -> DRAIN; mem_addr holds old value until ack; data dropped; next fetch at redirected address; no pc_update_en for the dropped fetch.
- Assert rst mid-REQ -> mem_req, instr_valid low immediately (async); after release, fetch restarts from the current PC value.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus width, FSM state
// encoding and a helper that says which states keep a memory request open.
package fetch_unit_pkg;

    // Width of the address/instruction bus shared with the program counter.
    localparam int XBUS = 32;

    // Top bit of the fetch FSM state vector.
    localparam int FETCH_STATE_MSB = 1;

    typedef enum logic [FETCH_STATE_MSB:0] {
        FETCH_IDLE  = 2'd0,  // no request; waits one cycle after reset
        FETCH_REQ   = 2'd1,  // request open at the live PC
        FETCH_HOLD  = 2'd2,  // instruction register full, waiting for decoder
        FETCH_DRAIN = 2'd3   // request open for a stale address, data will be dropped
    } fetch_state_e;

    // A request is outstanding to memory in exactly these states.
    function automatic logic request_open(input fetch_state_e s);
        return (s == FETCH_REQ) || (s == FETCH_DRAIN);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads the PC, fetches the word at that address over
// a req/ack memory handshake, and hands it to the decoder through a
// single-entry valid/ready register. Advances the PC (INC) once per good
// fetch and discards stale data when the PC is redirected (flush).
//
// Optional build macro FETCH_FAULT_EN: adds mem_err/instr_fault. A fetch that
// completes with mem_err delivers a zero instruction flagged as faulted; once
// the decoder accepts it the unit parks in IDLE until the next flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int XLEN             = XBUS,
    parameter bit RESET_ADDR_CHECK = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_current,
    output logic            pc_update_en,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_req,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
`ifdef FETCH_FAULT_EN
    input  logic            mem_err,
    output logic            instr_fault,
`endif
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            flush
);

    // The reset-address check is a reserved hook; only the disabled value is legal.
    generate
        if (RESET_ADDR_CHECK != 1'b0) begin : g_bad_reset_addr_check
            $error("fetch_unit: RESET_ADDR_CHECK is reserved and must be 0");
        end
    endgenerate

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] drain_addr;   // address of the request abandoned by a flush
    logic            load_word;    // capture mem_rdata into the instruction register
    logic            drop_instr;   // empty the instruction register
    logic            capture_drain;

`ifdef FETCH_FAULT_EN
    logic            load_fault;   // capture a faulted fetch
    logic            halted;       // parked after a faulted instruction was consumed
    logic            halt_next;
`endif

    // While draining, keep presenting the old address; the PC has already moved on.
    assign mem_addr = (state == FETCH_DRAIN) ? drain_addr : pc_current;

    // Next-state and control decode for the fetch FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_next    = state;
        pc_update_en  = 1'b0;
        load_word     = 1'b0;
        drop_instr    = 1'b0;
        capture_drain = 1'b0;
`ifdef FETCH_FAULT_EN
        load_fault    = 1'b0;
        halt_next     = halted;
`endif

        case (state)
            FETCH_IDLE: begin
`ifdef FETCH_FAULT_EN
                // After a consumed fault, only a redirect restarts fetching.
                if (!halted || flush) begin
                    state_next = FETCH_REQ;
                    halt_next  = 1'b0;
                end
`else
                state_next = FETCH_REQ;
`endif
            end

            FETCH_REQ: begin
                if (mem_ack) begin
                    if (flush) begin
                        // Completed word belongs to the old path; reissue at the new PC.
                        state_next = FETCH_REQ;
                    end
`ifdef FETCH_FAULT_EN
                    else if (mem_err) begin
                        load_fault = 1'b1;
                        state_next = FETCH_HOLD;
                    end
`endif
                    else begin
                        pc_update_en = 1'b1;
                        load_word    = 1'b1;
                        state_next   = FETCH_HOLD;
                    end
                end else if (flush) begin
                    // The request cannot be withdrawn; wait it out at the old address.
                    capture_drain = 1'b1;
                    state_next    = FETCH_DRAIN;
                end
            end

            FETCH_HOLD: begin
                if (flush) begin
                    drop_instr = 1'b1;
                    state_next = FETCH_REQ;
                end else if (instr_ready) begin
                    drop_instr = 1'b1;
                    state_next = FETCH_REQ;
`ifdef FETCH_FAULT_EN
                    if (instr_fault) begin
                        state_next = FETCH_IDLE;
                        halt_next  = 1'b1;
                    end
`endif
                end
            end

            FETCH_DRAIN: begin
                // Flush here has no further effect; the stale word is simply dropped.
                if (mem_ack) begin
                    state_next = FETCH_REQ;
                end
            end

            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    // FSM state register and the registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state   <= FETCH_IDLE;
            mem_req <= 1'b0;
        end else begin
            state   <= state_next;
            mem_req <= request_open(state_next);
        end
    end

`ifdef FETCH_FAULT_EN
    // Park flag set when a faulted instruction is consumed, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else begin
            halted <= halt_next;
        end
    end
`endif

    // Single-entry instruction register presented to the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_FAULT_EN
            instr_fault <= 1'b0;
`endif
        end else if (load_word) begin
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
            instr_valid <= 1'b1;
        end
`ifdef FETCH_FAULT_EN
        else if (load_fault) begin
            instr       <= '0;
            instr_pc    <= mem_addr;
            instr_valid <= 1'b1;
            instr_fault <= 1'b1;
        end
`endif
        else if (drop_instr) begin
            instr_valid <= 1'b0;
`ifdef FETCH_FAULT_EN
            instr_fault <= 1'b0;
`endif
        end
    end

    // Address of the request in flight when a flush arrived in REQ.
    always_ff @(posedge clk) begin
        // NOTE: no reset on this register; it is written on entry to DRAIN and
        // only read while in DRAIN, so its power-up value is never observed.
        if (capture_drain) begin
            drain_addr <= pc_current;
        end
    end

endmodule
